// File: rtl/c_mult_pkg.sv
// Shared types for the complex-multiplier partial-product stage: FSM states,
// product-select codes and width helpers (W = 2**(N-1), P = 2**N).
package c_mult_pkg;

   localparam int N_DEF = 4;

   function automatic int w_of(input int n);
      return 2 ** (n - 1);
   endfunction

   function automatic int p_of(input int n);
      return 2 ** n;
   endfunction

   typedef enum logic [2:0] {
      IDLE, MUL_RR, MUL_II, OUT_RE, MUL_RI, MUL_IR, OUT_IM
   } state_t;

   typedef enum logic [1:0] {
      SEL_RR, SEL_II, SEL_RI, SEL_IR
   } sel_t;

endpackage

// File: rtl/c_mult_pp_seq_seq_mul.sv
// Signed WxW shift-add multiplier: start_i pulses on cycle 0, done_o/prod_o are valid
// combinationally on cycle W-1; operands must stay stable meanwhile, no backpressure.
module seq_mul #(
   parameter  int W  = 8,
   localparam int P  = 2 * W,
   localparam int CW = $clog2(W + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic         done_o,
   output logic [P-1:0] prod_o
);

   logic [W:0]    ma, mb;
   logic          neg, step;
   logic [CW-1:0] k, cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic [P-1:0]  acc_q, acc_d, pp, acc_nxt;

   // W+1-bit magnitudes keep |-2**(W-1)| representable
   always_comb begin
      ma      = a_i[W-1] ? (~{a_i[W-1], a_i} + (W+1)'(1)) : {a_i[W-1], a_i};
      mb      = b_i[W-1] ? (~{b_i[W-1], b_i} + (W+1)'(1)) : {b_i[W-1], b_i};
      neg     = a_i[W-1] ^ b_i[W-1];
      step    = start_i | busy_q;
      k       = start_i ? '0 : cnt_q;
      pp      = mb[k] ? ({{(P-W-1){1'b0}}, ma} << k) : '0;
      acc_nxt = (start_i ? '0 : acc_q) + pp;
      done_o  = step && (k == CW'(W - 1));
      prod_o  = neg ? (~acc_nxt + P'(1)) : acc_nxt;
      busy_d  = busy_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      if (step) begin
         acc_d  = acc_nxt;
         cnt_d  = k + CW'(1);
         busy_d = !done_o;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         acc_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
      end
   end

endmodule

// File: rtl/c_mult_pp_seq.sv
// Sequential partial products for c_multiplier (a*b, or a*conj(b) with C_MULT_CONJ_EN); real pair
// valid 2W+1 cycles after accept, imag pair 2W+1 after real handshake; out_ready=0 freezes all outputs.
module c_mult_pp_seq
   import c_mult_pkg::*;
#(
   parameter  int N = N_DEF,
   localparam int W = w_of(N),
   localparam int P = p_of(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] ar,
   input  logic [W-1:0] ai,
   input  logic [W-1:0] br,
   input  logic [W-1:0] bi,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [P-1:0] out_x,
   output logic [P-1:0] out_y,
   output logic         out_add,
   output logic         out_imag
);

`ifdef C_MULT_CONJ_EN
   localparam bit CONJ = 1'b1;
`else
   localparam bit CONJ = 1'b0;
`endif

   state_t       state_q, state_d;
   sel_t         sel;
   logic         start_q, start_d;
   logic [W-1:0] ar_q, ai_q, br_q, bi_q, ar_d, ai_d, br_d, bi_d;
   logic [P-1:0] p0_q, p1_q, p0_d, p1_d;
   logic [W-1:0] mul_a, mul_b;
   logic         mul_done;
   logic [P-1:0] mul_prod;

   seq_mul #(.W(W)) u_mul (
      .clk    (clk),
      .rst_n  (rst_n),
      .start_i(start_q),
      .a_i    (mul_a),
      .b_i    (mul_b),
      .done_o (mul_done),
      .prod_o (mul_prod)
   );

   always_comb begin
      state_d = state_q;
      start_d = 1'b0;
      sel     = SEL_RR;
      ar_d    = ar_q;
      ai_d    = ai_q;
      br_d    = br_q;
      bi_d    = bi_q;
      p0_d    = p0_q;
      p1_d    = p1_q;
      case (state_q)
         IDLE: if (in_valid) begin
            ar_d    = ar;
            ai_d    = ai;
            br_d    = br;
            bi_d    = bi;
            state_d = MUL_RR;
            start_d = 1'b1;
         end
         MUL_RR: if (mul_done) begin
            p0_d    = mul_prod;
            state_d = MUL_II;
            start_d = 1'b1;
         end
         MUL_II: begin
            sel = SEL_II;
            if (mul_done) begin
               p1_d    = mul_prod;
               state_d = OUT_RE;
            end
         end
         OUT_RE: if (out_ready) begin
            state_d = MUL_RI;
            start_d = 1'b1;
         end
         // conjugate build swaps the imag pair so add_sub yields ai*br - ar*bi
         MUL_RI: begin
            sel = SEL_RI;
            if (mul_done) begin
               if (CONJ) p1_d = mul_prod;
               else      p0_d = mul_prod;
               state_d = MUL_IR;
               start_d = 1'b1;
            end
         end
         MUL_IR: begin
            sel = SEL_IR;
            if (mul_done) begin
               if (CONJ) p0_d = mul_prod;
               else      p1_d = mul_prod;
               state_d = OUT_IM;
            end
         end
         OUT_IM: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mul_a = ar_q;
      mul_b = br_q;
      case (sel)
         SEL_II: begin mul_a = ai_q; mul_b = bi_q; end
         SEL_RI: begin mul_a = ar_q; mul_b = bi_q; end
         SEL_IR: begin mul_a = ai_q; mul_b = br_q; end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         ar_q    <= '0;
         ai_q    <= '0;
         br_q    <= '0;
         bi_q    <= '0;
         p0_q    <= '0;
         p1_q    <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         ar_q    <= ar_d;
         ai_q    <= ai_d;
         br_q    <= br_d;
         bi_q    <= bi_d;
         p0_q    <= p0_d;
         p1_q    <= p1_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == OUT_RE) || (state_q == OUT_IM);
   assign out_x     = p0_q;
   assign out_y     = p1_q;
   assign out_imag  = (state_q == OUT_IM);
   assign out_add   = CONJ ? (state_q == OUT_RE) : (state_q == OUT_IM);

endmodule

// File: tb/tb_c_mult_pp_seq.sv
// Scoreboard bench for c_mult_pp_seq (N=4): complex-arithmetic model, directed cases plus random traffic.
module tb_c_mult_pp_seq;

   localparam int N = 4;
   localparam int W = 8;
   localparam int P = 16;

   logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready, out_add, out_imag;
   logic [W-1:0] ar, ai, br, bi;
   logic [P-1:0] out_x, out_y;
   logic         dir_rdy, rnd_rdy, rand_mode, b2b_chk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_hs = -1000;
   bit in_pair = 0;

   typedef struct {
      longint x;
      longint y;
      bit     add;
      bit     imag;
      longint res;
      int     start;
   } exp_t;

   exp_t q[$];
   exp_t e;

   c_mult_pp_seq #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .ar(ar), .ai(ai), .br(br), .bi(bi),
      .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
      .out_add(out_add), .out_imag(out_imag)
   );

   assign out_ready = rand_mode ? rnd_rdy : dir_rdy;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      #1 rnd_rdy = ($urandom_range(0, 3) != 0);
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // model: complex product from plain integer arithmetic, and the product pair each half should show
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         in_pair = 0;
      end else begin
         if (in_valid && in_ready) begin
            longint sar, sai, sbr, sbi;
            exp_t re, im;
            sar = longint'($signed(ar));
            sai = longint'($signed(ai));
            sbr = longint'($signed(br));
            sbi = longint'($signed(bi));
`ifdef C_MULT_CONJ_EN
            re = '{sar * sbr, sai * sbi, 1'b1, 1'b0, sar * sbr + sai * sbi, cyc + 2 * W + 1};
            im = '{sai * sbr, sar * sbi, 1'b0, 1'b1, sai * sbr - sar * sbi, 0};
`else
            re = '{sar * sbr, sai * sbi, 1'b0, 1'b0, sar * sbr - sai * sbi, cyc + 2 * W + 1};
            im = '{sar * sbi, sai * sbr, 1'b1, 1'b1, sar * sbi + sai * sbr, 0};
`endif
            q.push_back(re);
            q.push_back(im);
            if (b2b_chk) chk("b2b_accept_cycle", cyc, last_hs + 1);
         end
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_out_valid", 1, 0);
            end else begin
               longint ax, ay;
               e = q[0];
               ax = longint'($signed(out_x));
               ay = longint'($signed(out_y));
               if (!in_pair)
                  chk(e.imag ? "imag_latency" : "real_latency", cyc,
                      e.imag ? last_hs + 2 * W + 1 : e.start);
               chk("out_x", ax, e.x);
               chk("out_y", ay, e.y);
               chk("out_add", out_add, e.add);
               chk("out_imag", out_imag, e.imag);
               chk("in_ready_busy", in_ready, 0);
               chk("addsub_result", out_add ? ax + ay : ax - ay, e.res);
               if (out_ready) begin
                  void'(q.pop_front());
                  last_hs = cyc;
                  in_pair = 0;
               end else begin
                  in_pair = 1;
               end
            end
         end else if (in_pair) begin
            chk("valid_held_in_stall", 0, 1);
            in_pair = 0;
         end
      end
   end

   task automatic wait_accept();
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 600) begin
         @(negedge clk);
         n++;
      end
      chk("accept_within_budget", n < 600, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] a_r, a_i, b_r, b_i);
      ar = a_r; ai = a_i; br = b_r; bi = b_i;
      in_valid = 1'b1;
      wait_accept();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_within_budget", n < 3000, 1);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] rnd_op();
      case ($urandom_range(0, 7))
         0: return 8'h80;
         1: return 8'h7f;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; dir_rdy = 1'b1; rand_mode = 1'b0; b2b_chk = 1'b0;
      ar = '0; ai = '0; br = '0; bi = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_x", out_x, 0);
      chk("rst_out_y", out_y, 0);
      chk("rst_out_add", out_add, 0);
      chk("rst_out_imag", out_imag, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      send(8'd3, 8'd4, 8'd5, 8'd6);
      drain();
      send(8'h80, 8'h80, 8'h80, 8'h7f);
      drain();

      // stall in OUT_RE for 10 cycles
      dir_rdy = 1'b0;
      send(8'd9, 8'hf9, 8'hfd, 8'd11);
      begin
         int n = 0;
         while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
         end
         chk("stall_reached_out", out_valid, 1);
      end
      repeat (10) @(posedge clk);
      #1 dir_rdy = 1'b1;
      drain();

      // in_valid held high across two transactions
      ar = 8'd2; ai = 8'hfe; br = 8'd7; bi = 8'd1;
      in_valid = 1'b1;
      wait_accept();
      ar = 8'h80; ai = 8'd5; br = 8'hff; bi = 8'h80;
      b2b_chk = 1'b1;
      wait_accept();
      in_valid = 1'b0;
      b2b_chk = 1'b0;
      drain();

      // reset in the middle of MUL_II
      send(8'd7, 8'hfd, 8'd2, 8'd5);
      repeat (W + 2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out_x", out_x, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(8'd1, 8'd1, 8'd1, 8'hff);
      drain();

      rand_mode = 1'b1;
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         send(rnd_op(), rnd_op(), rnd_op(), rnd_op());
      end
      drain();
      rand_mode = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
